// File: rtl/result_streamer.sv
// Streams the downscaled image and then the counter block from shared memory as bytes over valid/ready.
// First byte is valid RD_LAT+1 cycles after start; reads are credit-limited so m_ready stalls never drop returning data.
module result_streamer #(
  parameter logic [18:0] OUT_BASE   = 19'h40000,
  parameter logic [18:0] STAT_BASE  = 19'h58000,
  parameter int          STAT_BYTES = 6,
  parameter int          RD_LAT     = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        start,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  output logic        busy,
  output logic        done,
  output logic        mem_re,
  output logic [18:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_data_in,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_SLOT = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]       img_n, total, issued, sent;
  logic [31:0]       img_n_nxt, total_nxt, issued_nxt, sent_nxt, stat_off;
  logic [CW-1:0]     occ, occ_nxt, cnt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [RD_LAT-1:0] vld_sr;
  logic              launch, push, pop;
  logic              mem_re_nxt;
  logic [18:0]       mem_addr_nxt;

  assign launch  = mem_re && mem_gnt;
  assign push    = vld_sr[RD_LAT-1];
  assign m_valid = (cnt != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_mem[rd_ptr];
  assign m_last  = m_valid && (sent == total - 32'd1);
  assign busy    = (state == STREAM) || (state == DRAIN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt  = state;
    img_n_nxt  = img_n;
    total_nxt  = total;
    issued_nxt = issued + 32'(launch);
    sent_nxt   = sent + 32'(pop);
    // occ counts FIFO entries plus reads in flight; a free slot is a credit
    occ_nxt    = occ + CW'(launch) - CW'(pop);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = STREAM;
          img_n_nxt  = 32'(cfg_width >> 1) * 32'(cfg_height >> 1);
          total_nxt  = img_n_nxt + 32'(STAT_BYTES);
          issued_nxt = '0;
          sent_nxt   = '0;
        end
      end
      STREAM:  if (issued_nxt == total) state_nxt = DRAIN;
      DRAIN:   if (sent_nxt == total) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    stat_off     = issued_nxt - img_n_nxt;
    mem_addr_nxt = (issued_nxt < img_n_nxt) ? OUT_BASE + issued_nxt[18:0]
                                            : STAT_BASE + stat_off[18:0];
    mem_re_nxt   = (state_nxt == STREAM) && (issued_nxt < total_nxt) && (occ_nxt < DEPTH_C);
    if (state == STREAM && !mem_gnt) begin
      mem_re_nxt   = mem_re;
      mem_addr_nxt = mem_addr;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= IDLE;
      img_n    <= '0;
      total    <= '0;
      issued   <= '0;
      sent     <= '0;
      occ      <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      vld_sr   <= '0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      img_n    <= img_n_nxt;
      total    <= total_nxt;
      issued   <= issued_nxt;
      sent     <= sent_nxt;
      occ      <= occ_nxt;
      mem_re   <= mem_re_nxt;
      mem_addr <= mem_addr_nxt;
      vld_sr   <= (vld_sr << 1) | RD_LAT'(launch);
      cnt      <= cnt + CW'(push) - CW'(pop);
      if (push) begin
        fifo_mem[wr_ptr] <= mem_data_in;
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: memory returns addr[7:0] two cycles after each launch.
module tb_result_streamer;

  logic        clk = 1'b0;
  logic        aclr;
  logic        start;
  logic [15:0] cfg_width, cfg_height;
  logic        busy, done, mem_re, mem_gnt, m_valid, m_last, m_ready;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data_in, m_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  got_dat[$];
  logic        got_last[$];
  logic [18:0] addrs[$];
  int launched = 0, popped = 0;
  int start_cyc = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0;
  bit first_seen = 0;
  bit stall_prev = 0, gl_prev = 0, prev_last = 0, prev_re = 0;
  logic [7:0]  prev_dat = '0;
  logic [18:0] prev_addr = '0;
  logic [18:0] rd_a;

  result_streamer dut (
    .clk(clk), .aclr(aclr), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_data_in(mem_data_in), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage read pipe; untagged cycles return 0xFF so stray pushes are visible
  always @(posedge clk) begin
    rd_a        <= (mem_re && mem_gnt) ? mem_addr : 19'h7ffff;
    mem_data_in <= rd_a[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (aclr) begin
      launched   = 0;
      popped     = 0;
      stall_prev = 0;
      gl_prev    = 0;
    end else begin
      if (start && !busy && !done) start_cyc = cyc + 1;
      if (m_valid && !first_seen) begin
        first_seen = 1;
        first_cyc  = cyc;
      end
      if (stall_prev) begin
        check("stall_dat", m_data, prev_dat);
        check("stall_last", m_last, prev_last);
      end
      if (gl_prev && !mem_gnt) begin
        check("gnt_addr", mem_addr, prev_addr);
        check("gnt_re", mem_re, prev_re);
      end
      if (mem_re && mem_gnt) begin
        check("credit", (launched - popped) < 4, 1);
        launched++;
        addrs.push_back(mem_addr);
      end
      if (m_valid && m_ready) begin
        got_dat.push_back(m_data);
        got_last.push_back(m_last);
        popped++;
        if (m_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = m_valid && !m_ready;
      prev_dat   = m_data;
      prev_last  = m_last;
      gl_prev    = !mem_gnt;
      prev_addr  = mem_addr;
      prev_re    = mem_re;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_re"}, mem_re, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_last"}, m_last, 0);
  endtask

  // mode: 0 plain, 1 m_ready 1-0-0-1, 2 grant stall, 3 start while busy, 4 reset at byte 5
  task automatic run(input int w, input int h, input int mode);
    int img, tot;
    bit restarted, aborted;
    logic [18:0] ea;
    img = (w / 2) * (h / 2);
    tot = img + 6;
    restarted = 0;
    aborted = 0;
    @(posedge clk); #1;
    got_dat.delete();
    got_last.delete();
    addrs.delete();
    first_seen = 0;
    done_cnt = 0;
    cfg_width = 16'(w);
    cfg_height = 16'(h);
    start = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = 0;
      m_ready = (mode == 1) ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      mem_gnt = !(mode == 2 && c >= 4 && c < 9);
      if (mode == 3 && !restarted && got_dat.size() == 3) begin
        start = 1;
        restarted = 1;
      end
      if (mode == 4 && got_dat.size() >= 5) begin
        aborted = 1;
        break;
      end
      if (done_cnt > 0) break;
    end
    m_ready = 1;
    mem_gnt = 1;
    if (aborted) begin
      aclr = 1;
      #1;
      check_idle_outputs("abort");
      @(posedge clk); #1;
      aclr = 0;
      repeat (10) @(posedge clk);
      check("abort_no_done", done_cnt, 0);
    end else begin
      check("done_seen", done_cnt > 0, 1);
      @(posedge clk);
      @(negedge clk);
      check("done_once", done_cnt, 1);
      check("busy_after", busy, 0);
      check("done_after_last", done_cyc - last_cyc, 1);
      check("latency", first_cyc - start_cyc, 3);
      check("nbytes", got_dat.size(), tot);
      check("nlaunch", addrs.size(), tot);
      for (int k = 0; k < tot; k++) begin
        ea = (k < img) ? 19'h40000 + 19'(k) : 19'h58000 + 19'(k - img);
        if (k < addrs.size()) check("addr", addrs[k], ea);
        if (k < got_dat.size()) begin
          check("byte", got_dat[k], ea[7:0]);
          check("last", got_last[k], k == tot - 1);
        end
      end
    end
  endtask

  initial begin
    aclr = 1;
    start = 0;
    cfg_width = 0;
    cfg_height = 0;
    mem_gnt = 1;
    m_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    aclr = 0;
    run(8, 4, 0);
    run(8, 4, 1);
    run(8, 4, 2);
    run(1, 480, 0);
    run(8, 4, 3);
    run(8, 4, 0);
    run(8, 4, 4);
    run(8, 4, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
